hack_mem_router: RTL
====================

// Module: hack_mem_router
// PURPOSE
//  Sequential, parametrised successor of the Hack address decoder. Sits between the CPU data port and the RAM/SCREEN/KBD devices.
//  Latches one CPU request at a time and decodes it into one of three regions with per-region wait states.
//  Returns the muxed read data with a one-cycle ready pulse, or flags an error for unmapped addresses or keyboard writes.
// PARAMETERS
//  ADDR_W       15     CPU address width (bits)
//  DATA_W       16     data width (bits)
//  RAM_TOP      16383  last RAM address; RAM spans 0..RAM_TOP
//  SCR_BASE     16384  first SCREEN address
//  SCR_TOP      24575  last SCREEN address
//  KBD_ADDR     24576  single keyboard address
//  RAM_WAIT     0      extra wait cycles for a RAM access (0..15)
//  SCR_WAIT     1      extra wait cycles for a SCREEN access (0..15)
//  KBD_WAIT     0      extra wait cycles for a KBD access (0..15)
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       synchronous, active-low reset
//  cpu_req       in   1       request strobe, sampled only in IDLE
//  cpu_we        in   1       1 = write, 0 = read
//  cpu_addr      in   ADDR_W  byte-less word address
//  cpu_wdata     in   DATA_W  write data
//  cpu_rdata     out  DATA_W  read data, valid while cpu_ready=1
//  cpu_ready     out  1       one-cycle completion pulse
//  cpu_err       out  1       qualifies cpu_ready: access was unmapped or illegal
//  ram_sel       out  1       RAM select
//  scr_sel       out  1       SCREEN select
//  kbd_sel       out  1       KBD select
//  dev_we        out  1       write strobe, final access cycle only
//  dev_addr      out  ADDR_W  region-relative offset (addr - region base)
//  dev_wdata     out  DATA_W  latched write data
//  ram_rdata     in   DATA_W  RAM read data
//  scr_rdata     in   DATA_W  SCREEN read data
//  kbd_rdata     in   DATA_W  KBD read data
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0, including cpu_rdata, selects and counters.
//  - FSM states:
//    - IDLE:
//      - cpu_req=1 latches we, addr and wdata.
//      - Mapped address -> ACCESS; wait counter loaded with the region WAIT.
//      - Unmapped address (>KBD_ADDR), or write to KBD_ADDR -> DONE with err. No select is asserted.
//    - ACCESS:
//      - Exactly one select is held high and dev_addr/dev_wdata are stable.
//      - Counter decrements each cycle. On counter==0 (final cycle): dev_we=latched we; if read, capture region rdata. Next state DONE.
//    - DONE: cpu_ready=1 for exactly one cycle; cpu_err valid. Next state IDLE.
//  - Latency, req sampled at edge 0:
//    - Mapped access with W waits: selects high for W+1 cycles; cpu_ready in cycle W+2.
//    - Error access: cpu_ready in cycle 1.
//  - cpu_req while not IDLE is ignored, not queued.
//  - A new request may be sampled in the cycle after DONE. Max throughput is 1 access per W+3 cycles.
//  - cpu_rdata is held until the next capture. Writes and errors leave it unchanged.
//  - Decode uses the full ADDR_W compare. Boundaries are inclusive:
//    - RAM_TOP -> RAM.
//    - SCR_BASE, SCR_TOP -> SCREEN.
//    - KBD_ADDR -> KBD.
//    - KBD_ADDR+1 and above -> error.
//  - Offset arithmetic is ADDR_W wide and unsigned; no wrap occurs for legal params.
//  - rst_n=0 mid-ACCESS: the FSM returns to IDLE at that edge and selects drop. No dev_we is issued if reset lands before the final cycle. No ready pulse.
// CONFIGURATION
//  - Macro HACK_MEM_ROUTER_STATS_EN:
//    - Defined: adds outputs acc_cnt[15:0] (completed mapped accesses) and err_cnt[15:0] (error completions).
//    - Both counters increment in the DONE cycle, saturate at 16'hFFFF and clear on reset.
//  - Undefined: ports and counter logic are absent; all other behaviour is identical.
// TESTING
//  - Read RAM addr 5, ram_rdata=16'h1234, RAM_WAIT=0 -> ram_sel high 1 cycle, dev_addr=5; ready+rdata=16'h1234 at cycle 2, err=0.
//  - Write SCREEN addr 16385, wdata=16'hBEEF, SCR_WAIT=1 -> scr_sel 2 cycles, dev_addr=1; dev_we only in the 2nd cycle; ready at cycle 3.
//  - Read 24576, kbd_rdata=16'h0041 -> kbd_sel, dev_addr=0; rdata=16'h0041. Write 24576 -> ready+err at cycle 1, no select.
//  - Read 24577 and 32767 -> ready+err at cycle 1; rdata keeps its previous value.
//  - Boundaries 16383/16384/24575 -> RAM / SCREEN / SCREEN. cpu_req held high while busy -> only one access.
//  - rst_n low during the SCREEN write wait cycle -> no dev_we, no ready, all outputs 0. STATS_EN: counters 0 after reset, then 1 acc, 1 err.

Source files
------------

// File: rtl/hack_mem_router.sv
// Hack memory router: latches one CPU request, decodes RAM/SCREEN/KBD with per-region wait states.
// Optional HACK_MEM_ROUTER_STATS_EN adds saturating access/error counters.
module hack_mem_router #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int RAM_TOP  = 16383,
    parameter int SCR_BASE = 16384,
    parameter int SCR_TOP  = 24575,
    parameter int KBD_ADDR = 24576,
    parameter int RAM_WAIT = 0,
    parameter int SCR_WAIT = 1,
    parameter int KBD_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    output logic              ram_sel,
    output logic              scr_sel,
    output logic              kbd_sel,
    output logic              dev_we,
    output logic [ADDR_W-1:0] dev_addr,
    output logic [DATA_W-1:0] dev_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] scr_rdata,
`ifdef HACK_MEM_ROUTER_STATS_EN
    output logic [15:0]       acc_cnt,
    output logic [15:0]       err_cnt,
`endif
    input  logic [DATA_W-1:0] kbd_rdata
);

    localparam logic [ADDR_W-1:0] L_RAM_TOP  = ADDR_W'(RAM_TOP);
    localparam logic [ADDR_W-1:0] L_SCR_BASE = ADDR_W'(SCR_BASE);
    localparam logic [ADDR_W-1:0] L_SCR_TOP  = ADDR_W'(SCR_TOP);
    localparam logic [ADDR_W-1:0] L_KBD_ADDR = ADDR_W'(KBD_ADDR);
    localparam logic [3:0]        L_RAM_WAIT = 4'(RAM_WAIT);
    localparam logic [3:0]        L_SCR_WAIT = 4'(SCR_WAIT);
    localparam logic [3:0]        L_KBD_WAIT = 4'(KBD_WAIT);

    localparam logic [1:0] RG_RAM  = 2'd0;
    localparam logic [1:0] RG_SCR  = 2'd1;
    localparam logic [1:0] RG_KBD  = 2'd2;
    localparam logic [1:0] RG_NONE = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t              r_state, w_next;
    logic                r_we;
    logic                r_err;
    logic [1:0]          r_region;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_off;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic [1:0]          w_region;
    logic [ADDR_W-1:0]   w_off;
    logic [3:0]          w_wait;
    logic                w_err_req;
    logic                w_final;
    logic [DATA_W-1:0]   w_rmux;

    // Address decode of the live CPU address; only consumed when a request is sampled in IDLE.
    always_comb begin
        w_region = RG_NONE;
        w_off    = '0;
        w_wait   = '0;
        if (cpu_addr <= L_RAM_TOP) begin
            w_region = RG_RAM;
            w_off    = cpu_addr;
            w_wait   = L_RAM_WAIT;
        end else if (cpu_addr >= L_SCR_BASE && cpu_addr <= L_SCR_TOP) begin
            w_region = RG_SCR;
            w_off    = cpu_addr - L_SCR_BASE;
            w_wait   = L_SCR_WAIT;
        end else if (cpu_addr == L_KBD_ADDR) begin
            w_region = RG_KBD;
            w_wait   = L_KBD_WAIT;
        end
    end

    assign w_err_req = (w_region == RG_NONE) || (w_region == RG_KBD && cpu_we);
    assign w_final   = (r_state == S_ACCESS) && (r_cnt == 4'd0);

    always_comb begin
        w_rmux = '0;
        case (r_region)
            RG_RAM:  w_rmux = ram_rdata;
            RG_SCR:  w_rmux = scr_rdata;
            RG_KBD:  w_rmux = kbd_rdata;
            default: w_rmux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cpu_req) w_next = w_err_req ? S_DONE : S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ram_sel   = 1'b0;
        scr_sel   = 1'b0;
        kbd_sel   = 1'b0;
        dev_we    = 1'b0;
        cpu_ready = 1'b0;
        cpu_err   = 1'b0;
        if (r_state == S_ACCESS) begin
            ram_sel = (r_region == RG_RAM);
            scr_sel = (r_region == RG_SCR);
            kbd_sel = (r_region == RG_KBD);
            dev_we  = w_final && r_we;
        end
        if (r_state == S_DONE) begin
            cpu_ready = 1'b1;
            cpu_err   = r_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_region <= RG_NONE;
            r_cnt    <= '0;
            r_off    <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else if (r_state == S_IDLE && cpu_req) begin
            r_we     <= cpu_we;
            r_wdata  <= cpu_wdata;
            r_off    <= w_off;
            r_cnt    <= w_wait;
            r_err    <= w_err_req;
            r_region <= w_err_req ? RG_NONE : w_region;
        end else if (r_state == S_ACCESS) begin
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            else if (!r_we)    r_rdata <= w_rmux;
        end
    end

    assign dev_addr  = r_off;
    assign dev_wdata = r_wdata;
    assign cpu_rdata = r_rdata;

`ifdef HACK_MEM_ROUTER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt <= '0;
            err_cnt <= '0;
        end else if (r_state == S_DONE) begin
            if (r_err && err_cnt != 16'hFFFF)       err_cnt <= err_cnt + 16'd1;
            else if (!r_err && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
        end
    end
`endif

endmodule
